// File: rtl/pacman_pkg.sv
// pacman_pkg: shared types and screen offsets for the Pac-Man play field.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a. Contents: dir_t, mover_state_t, OFFSETH/OFFSETV, in_range().
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    STOPPED = 1'b0,
    MOVING  = 1'b1
  } mover_state_t;

  // Play-field to raster offsets (custom border + blanking), shared with the wall block.
  localparam int unsigned OFFSETH = 274;
  localparam int unsigned OFFSETV = 58;

  // Inclusive range test on 11-bit screen coordinates.
  function automatic logic in_range(input logic [10:0] val,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/pacman_mover_probe_strip.sv
// probe_strip: flags when the raster sits in the STEP-deep strip just outside
// Pac-Man's box on one side. Latency: combinational. Backpressure: none.
// Ports: hCount/vCount raster, pos_x/pos_y play-field centre, dir side, hit flag.
module probe_strip
  import pacman_pkg::*;
#(
  parameter int HALF = 10,
  parameter int STEP = 2
) (
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  dir_t       dir,
  output logic       hit
);

  localparam logic [10:0] H   = 11'(HALF);
  localparam logic [10:0] S   = 11'(STEP);
  localparam logic [10:0] ONE = 11'd1;

  logic [10:0] hx, vy, sx, sy;

  // One extra bit so the offset centre plus box/strip reach never overflows.
  always_comb begin
    hx = {1'b0, hCount};
    vy = {1'b0, vCount};
    sx = {1'b0, pos_x} + 11'(OFFSETH);
    sy = {1'b0, pos_y} + 11'(OFFSETV);
    hit = 1'b0;
    unique case (dir)
      UP:    hit = in_range(vy, sy - H - S, sy - H - ONE) && in_range(hx, sx - H, sx + H);
      DOWN:  hit = in_range(vy, sy + H + ONE, sy + H + S) && in_range(hx, sx - H, sx + H);
      LEFT:  hit = in_range(hx, sx - H - S, sx - H - ONE) && in_range(vy, sy - H, sy + H);
      RIGHT: hit = in_range(hx, sx + H + ONE, sx + H + S) && in_range(vy, sy - H, sy + H);
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/pacman_mover.sv
// pacman_mover: frame-synchronous Pac-Man movement; probes wall pixels around
// the box during the scan and commits one position update per frame at COMMIT_LINE.
// Latency: position/dir/moving registered (update 1 cycle after commit pixel); pacFill combinational.
// Ports: clk/rst, hCount/vCount raster, wallFill, btnU/D/L/R, pacX/pacY/pacDir/moving, pacFill.
module pacman_mover
  import pacman_pkg::*;
#(
  parameter int HALF        = 10,
  parameter int STEP        = 2,
  parameter int MOVE_DIV    = 1,
  parameter int COMMIT_LINE = 515,
  parameter int START_X     = 190,
  parameter int START_Y     = 316
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       wallFill,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [9:0] pacX,
  output logic [9:0] pacY,
  output logic [1:0] pacDir,
  output logic       moving,
  output logic       pacFill
);

  localparam int DIVW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [9:0]  STEP10 = 10'(STEP);
  localparam logic [10:0] H11    = 11'(HALF);

  mover_state_t    state, state_nxt;
  dir_t            dir_q, dir_nxt, req_q, btn_dir;
  logic            req_valid, consume;
  logic [9:0]      pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic [3:0]      blk, strip_hit;
  logic [DIVW-1:0] div_q;
  logic            commit, step_frame, btn_any;

  assign commit     = (hCount == 10'd0) && (vCount == 10'(COMMIT_LINE));
  assign step_frame = (div_q == DIVW'(MOVE_DIV - 1));
  assign btn_any    = btnU | btnD | btnL | btnR;

  // Fixed priority U > D > L > R when several buttons are held together.
  always_comb begin
    btn_dir = RIGHT;
    if (btnU)      btn_dir = UP;
    else if (btnD) btn_dir = DOWN;
    else if (btnL) btn_dir = LEFT;
  end

  for (genvar d = 0; d < 4; d++) begin : g_strip
    localparam logic [1:0] DV = 2'(d);
    probe_strip #(.HALF(HALF), .STEP(STEP)) u_strip (
      .hCount (hCount),
      .vCount (vCount),
      .pos_x  (pos_x),
      .pos_y  (pos_y),
      .dir    (dir_t'(DV)),
      .hit    (strip_hit[d])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOPPED;
    else     state <= state_nxt;
  end

  // Next-state and commit decision. Uses the request held before any press
  // arriving in the commit cycle itself.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_q;
    consume   = 1'b0;
    pos_x_nxt = pos_x;
    pos_y_nxt = pos_y;
    if (commit && step_frame) begin
      if (req_valid && !blk[req_q]) begin
        state_nxt = MOVING;
        dir_nxt   = req_q;
        consume   = 1'b1;
      end else if (state == MOVING && !blk[dir_q]) begin
        state_nxt = MOVING;
      end else begin
        state_nxt = STOPPED;
      end
      if (state_nxt == MOVING) begin
        unique case (dir_nxt)
          UP:    pos_y_nxt = pos_y - STEP10;
          DOWN:  pos_y_nxt = pos_y + STEP10;
          LEFT:  pos_x_nxt = pos_x - STEP10;
          RIGHT: pos_x_nxt = pos_x + STEP10;
          default: ;
        endcase
      end
    end
  end

  // FSM outputs.
  always_comb begin
    moving = (state == MOVING);
    pacDir = dir_q;
    pacX   = pos_x;
    pacY   = pos_y;
  end

  // Datapath: position, request latch, blocked accumulators, frame divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x     <= 10'(START_X);
      pos_y     <= 10'(START_Y);
      dir_q     <= LEFT;
      req_q     <= UP;
      req_valid <= 1'b0;
      blk       <= '0;
      div_q     <= '0;
    end else begin
      pos_x <= pos_x_nxt;
      pos_y <= pos_y_nxt;
      dir_q <= dir_nxt;
      // The commit-cycle sample is dropped: clearing wins.
      if (commit) begin
        blk   <= '0;
        div_q <= step_frame ? '0 : div_q + DIVW'(1);
      end else begin
        blk <= blk | (strip_hit & {4{wallFill}});
      end
      // A fresh press overrides consumption of the old request.
      if (btn_any) begin
        req_q     <= btn_dir;
        req_valid <= 1'b1;
      end else if (consume) begin
        req_valid <= 1'b0;
      end
    end
  end

  // Box fill in screen coordinates.
  logic [10:0] fill_sx, fill_sy;
  always_comb begin
    fill_sx = {1'b0, pos_x} + 11'(OFFSETH);
    fill_sy = {1'b0, pos_y} + 11'(OFFSETV);
    pacFill = in_range({1'b0, hCount}, fill_sx - H11, fill_sx + H11) &&
              in_range({1'b0, vCount}, fill_sy - H11, fill_sy + H11);
  end

endmodule
